// File: rtl/ospfb_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// ospfb_capture_ctrl_if
// AXI-Stream style sample bus between the OSPFB output and the capture
// sequencer.
//
// Parameters:
//   WIDTH   tdata width (one packed complex sample per beat)
//
// Signals:
//   tdata   sample word, driven by the master
//   tvalid  sample valid, driven by the master
//   tlast   last beat of an FFT frame, driven by the master
//   tready  accept, driven by the slave
//
// Modports:
//   master  the OSPFB side (drives tdata/tvalid/tlast)
//   slave   the capture side (drives tready)
// ---------------------------------------------------------------------------
interface ospfb_capture_ctrl_if #(
  parameter int WIDTH = 64
);

  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/ospfb_capture_ctrl.sv
// ---------------------------------------------------------------------------
// ospfb_capture_ctrl
// Sequences capture of OSPFB output frames into a simple dual-port capture
// RAM. After an arm pulse the block waits for a frame boundary (a beat with
// tlast), then writes FRAMES*FFT_LEN consecutive beats starting at address 0
// and raises full. While capturing it records tlast misalignment and counts
// FFT overflow events.
//
// Parameters:
//   FFT_LEN   beats per frame
//   FRAMES    frames per capture
//   WIDTH     tdata width
//   DEPTH     FFT_LEN*FRAMES RAM words (derived)
//   ADDR_W    RAM address width (derived)
//
// Ports:
//   clk                 single clock
//   rst                 asynchronous active-high reset
//   en                  global enable; 0 stalls the stream and freezes state
//   arm                 1-cycle pulse: start a new capture
//   clear               1-cycle pulse: abandon/acknowledge, return to IDLE
//   s_axis              sample stream (slave modport), tready = en
//   event_fft_overflow  FFT overflow pulse
//   ram_we/addr/wdata   registered RAM write port (1 cycle after the beat)
//   full                capture complete
//   busy                waiting for a frame boundary or capturing
//   frame_cnt           completed frames in this capture
//   tlast_err           sticky tlast misalignment flag
//   ovf_cnt             saturating overflow count seen while capturing
//
// Build option:
//   OSPFB_CAPTURE_OVF_ABORT_EN  when defined, an overflow while capturing
//                               ends the capture on the next edge (full=1).
// ---------------------------------------------------------------------------
module ospfb_capture_ctrl #(
  parameter int  FFT_LEN = 2048,
  parameter int  FRAMES  = 32,
  parameter int  WIDTH   = 64,
  localparam int DEPTH   = FFT_LEN * FRAMES,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int FCNT_W  = $clog2(FRAMES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  arm,
  input  logic                  clear,
  ospfb_capture_ctrl_if.slave   s_axis,
  input  logic                  event_fft_overflow,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  output logic                  full,
  output logic                  busy,
  output logic [FCNT_W-1:0]     frame_cnt,
  output logic                  tlast_err,
  output logic [15:0]           ovf_cnt
);

  localparam int WCNT_W = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FFT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                beat;
  logic                write_beat;
  logic                clear_stats;
  logic                ovf_hit;
  logic                enter_done;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [WCNT_W-1:0]   word_cnt;

  // The only backpressure is the global enable, so a beat is simply a valid
  // sample while enabled.
  assign s_axis.tready = en;
  assign beat          = s_axis.tvalid & en;
  assign busy          = (state == ST_SYNC) || (state == ST_CAPTURE);
  assign enter_done    = (state == ST_CAPTURE) && (state_next == ST_DONE);

  // State register. Everything interesting happens in the next-state logic;
  // reset drops straight back to IDLE and discards any capture in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control strobes. clear is evaluated last so it wins over
  // arm and over any write in the same cycle. arm is only honoured from IDLE
  // and DONE. Beats are gated by en, so a stall freezes SYNC and CAPTURE.
  always_comb begin
    state_next  = state;
    clear_stats = 1'b0;
    write_beat  = 1'b0;
    ovf_hit     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (arm) begin
          state_next  = ST_SYNC;
          clear_stats = 1'b1;
        end
      end
      ST_SYNC: begin
        if (beat && s_axis.tlast) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        write_beat = beat;
        ovf_hit    = en & event_fft_overflow;
        if (beat && (addr_cnt == LAST_ADDR)) begin
          state_next = ST_DONE;
        end
`ifdef OSPFB_CAPTURE_OVF_ABORT_EN
        if (ovf_hit) begin
          state_next = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (arm) begin
          state_next  = ST_SYNC;
          clear_stats = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (clear) begin
      state_next  = ST_IDLE;
      clear_stats = 1'b1;
      write_beat  = 1'b0;
      ovf_hit     = 1'b0;
    end
  end

  // Address and in-frame word counters. They sit at zero outside CAPTURE so
  // the beat after the aligning tlast lands on address 0 / word 0. The word
  // counter free-runs and is never re-aligned by a misplaced tlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= '0;
      word_cnt <= '0;
    end else if (state != ST_CAPTURE) begin
      addr_cnt <= '0;
      word_cnt <= '0;
    end else if (write_beat) begin
      addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + ADDR_W'(1);
      word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + WCNT_W'(1);
    end
  end

  // Registered RAM write port. ram_we follows each accepted beat by one
  // cycle, so it drops the cycle after en falls; address and data hold their
  // last written value between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= write_beat;
      if (write_beat) begin
        ram_addr  <= addr_cnt;
        ram_wdata <= s_axis.tdata;
      end
    end
  end

  // Capture status. full rises on the same edge as the final write (or the
  // overflow abort). tlast_err is set when tlast disagrees with the frame
  // boundary the word counter expects. ovf_cnt saturates rather than wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 1'b0;
      frame_cnt <= '0;
      tlast_err <= 1'b0;
      ovf_cnt   <= '0;
    end else if (clear_stats) begin
      full      <= 1'b0;
      frame_cnt <= '0;
      tlast_err <= 1'b0;
      ovf_cnt   <= '0;
    end else begin
      if (enter_done) begin
        full <= 1'b1;
      end
      if (write_beat && (word_cnt == LAST_WORD)) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
      if (write_beat && (s_axis.tlast != (word_cnt == LAST_WORD))) begin
        tlast_err <= 1'b1;
      end
      if (ovf_hit && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

endmodule
